// File: rtl/banco_registradores_n_pkg.sv
// Shared types and default sizing for the register bank and its clear sequencer.
package banco_registradores_n_pkg;
   localparam int SIZE_DEF = 8;
   localparam int AW_DEF   = 3;

   typedef enum logic {IDLE = 1'b0, LIMPA = 1'b1} estado_t;
endpackage

// File: rtl/seq_limpeza.sv
// Bulk-clear sequencer: walks every address once, strobing a clear per cycle.
module seq_limpeza
   import banco_registradores_n_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          clr_req,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] clr_addr,
   output logic          clr_stb
);
   localparam logic [AW-1:0] LAST = '1;

   estado_t       estado, estado_next;
   logic [AW-1:0] cnt, cnt_next;
   logic          done_next;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         estado <= IDLE;
         cnt    <= '0;
         done   <= 1'b0;
      end else begin
         estado <= estado_next;
         cnt    <= cnt_next;
         done   <= done_next;
      end
   end

   always_comb begin
      estado_next = estado;
      cnt_next    = cnt;
      done_next   = 1'b0;
      busy        = 1'b0;
      clr_stb     = 1'b0;
      clr_addr    = cnt;
      case (estado)
         IDLE: begin
            if (clr_req) begin
               estado_next = LIMPA;
               cnt_next    = '0;
            end
         end
         LIMPA: begin
            busy    = 1'b1;
            clr_stb = 1'b1;
            // Leaving at the last address keeps the counter from wrapping.
            if (cnt == LAST) begin
               estado_next = IDLE;
               done_next   = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: estado_next = IDLE;
      endcase
   end
endmodule

// File: rtl/banco_registradores_n.sv
// Register bank: 2 combinational read ports, 1 write port, sequential bulk clear.
// Define BANCO_BYPASS_EN for write-through forwarding of accepted writes.
module banco_registradores_n
   import banco_registradores_n_pkg::*;
#(
   parameter int Size    = SIZE_DEF,
   parameter int AW      = AW_DEF,
   parameter int ZERO_R0 = 0
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic            we,
   input  logic [AW-1:0]   a3,
   input  logic [Size-1:0] wd,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   input  logic            clr_req,
   output logic [Size-1:0] rd1,
   output logic [Size-1:0] rd2,
   output logic            busy,
   output logic            done
);
   localparam int N = 2 ** AW;

   logic [N-1:0][Size-1:0] mem;
   logic [AW-1:0]          clr_addr;
   logic                   clr_stb;
   logic                   wr_ok;

   seq_limpeza #(.AW(AW)) u_seq (
      .clk      (clk),
      .clr_n    (clr_n),
      .clr_req  (clr_req),
      .busy     (busy),
      .done     (done),
      .clr_addr (clr_addr),
      .clr_stb  (clr_stb)
   );

   // A pending clear request takes priority over a same-cycle write.
   assign wr_ok = we && !busy && !clr_req && !((ZERO_R0 != 0) && (a3 == '0));

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)
         mem <= '0;
      else if (clr_stb)
         mem[clr_addr] <= '0;
      else if (wr_ok)
         mem[a3] <= wd;
   end

   always_comb begin
      rd1 = mem[a1];
      rd2 = mem[a2];
`ifdef BANCO_BYPASS_EN
      if (wr_ok && (a1 == a3)) rd1 = wd;
      if (wr_ok && (a2 == a3)) rd2 = wd;
`endif
      if ((ZERO_R0 != 0) && (a1 == '0)) rd1 = '0;
      if ((ZERO_R0 != 0) && (a2 == '0)) rd2 = '0;
   end
endmodule

// File: tb/tb_banco_registradores_n.sv
// Self-checking bench: array model of the bank compared every cycle, plus directed literal checks.
module tb_banco_registradores_n;
   logic       clk = 1'b0;
   logic       clr_n, we, clr_req;
   logic [2:0] a1, a2, a3;
   logic [7:0] wd;
   logic [7:0] rd1, rd2, rd1_z, rd2_z;
   logic       busy, done, busy_z, done_z;

   int errors = 0;
   int checks = 0;

   banco_registradores_n dut (
      .clk(clk), .clr_n(clr_n), .we(we), .a3(a3), .wd(wd), .a1(a1), .a2(a2),
      .clr_req(clr_req), .rd1(rd1), .rd2(rd2), .busy(busy), .done(done)
   );

   banco_registradores_n #(.ZERO_R0(1)) dut_z (
      .clk(clk), .clr_n(clr_n), .we(we), .a3(a3), .wd(wd), .a1(a1), .a2(a2),
      .clr_req(clr_req), .rd1(rd1_z), .rd2(rd2_z), .busy(busy_z), .done(done_z)
   );

   always #5 clk = ~clk;

   // Model: plain arrays plus a countdown of remaining clear cycles.
   logic [7:0] m0 [8];
   logic [7:0] m1 [8];
   int         clr_left, clr_idx;
   logic       done_m;

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 0; i < 8; i++) begin
            m0[i] <= 8'h00;
            m1[i] <= 8'h00;
         end
         clr_left <= 0;
         clr_idx  <= 0;
         done_m   <= 1'b0;
      end else begin
         done_m <= (clr_left == 1);
         if (clr_left > 0) begin
            m0[clr_idx] <= 8'h00;
            m1[clr_idx] <= 8'h00;
            clr_idx     <= clr_idx + 1;
            clr_left    <= clr_left - 1;
         end else if (clr_req) begin
            clr_left <= 8;
            clr_idx  <= 0;
         end else if (we) begin
            m0[a3] <= wd;
            if (a3 != 3'd0) m1[a3] <= wd;
         end
      end
   end

   function automatic logic [7:0] exp_rd(bit zr, logic [2:0] addr);
      bit acc;
      acc = we && (clr_left == 0) && !clr_req && !(zr && a3 == 3'd0);
      if (zr && addr == 3'd0) return 8'h00;
`ifdef BANCO_BYPASS_EN
      if (acc && addr == a3) return wd;
`else
      if (acc && 1'b0) return wd;
`endif
      return zr ? m1[addr] : m0[addr];
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("rd1", rd1, exp_rd(1'b0, a1));
      chk("rd2", rd2, exp_rd(1'b0, a2));
      chk("rd1_z", rd1_z, exp_rd(1'b1, a1));
      chk("rd2_z", rd2_z, exp_rd(1'b1, a2));
      chk("busy", {7'd0, busy}, {7'd0, clr_left > 0});
      chk("done", {7'd0, done}, {7'd0, done_m});
      chk("busy_z", {7'd0, busy_z}, {7'd0, clr_left > 0});
      chk("done_z", {7'd0, done_z}, {7'd0, done_m});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < 8; i++) begin
         we = 1'b1; a3 = 3'(i); wd = base + 8'(i);
         step();
      end
      we = 1'b0;
   endtask

   int nbusy, ndone;

   task automatic count_clear(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         a1 = 3'(i); a2 = 3'(7 - i);
         @(negedge clk);
         if (busy) nbusy++;
         if (done) ndone++;
         step();
         we = 1'b0; clr_req = 1'b0;
      end
   endtask

   initial begin
      clr_n = 1'b0; we = 1'b0; clr_req = 1'b0;
      a1 = 3'd0; a2 = 3'd0; a3 = 3'd0; wd = 8'h00;
      #12;
      chk("reset_rd1", rd1, 8'h00);
      chk("reset_busy", {7'd0, busy}, 8'h00);
      step();
      clr_n = 1'b1;

      // Two writes then read both back.
      we = 1'b1; a3 = 3'd3; wd = 8'h5A; step();
      a3 = 3'd7; wd = 8'hA5; step();
      we = 1'b0; a1 = 3'd3; a2 = 3'd7;
      @(negedge clk);
      chk("lit_r3", rd1, 8'h5A);
      chk("lit_r7", rd2, 8'hA5);
      step();

      // Same-cycle write and read of r2.
      we = 1'b1; a3 = 3'd2; wd = 8'h11; a1 = 3'd2;
      @(negedge clk);
`ifdef BANCO_BYPASS_EN
      chk("lit_fwd", rd1, 8'h11);
`else
      chk("lit_fwd", rd1, 8'h00);
`endif
      step();
      we = 1'b0;
      @(negedge clk);
      chk("lit_r2", rd1, 8'h11);
      step();

      // Writes to r0 are discarded when r0 is hardwired.
      we = 1'b1; a3 = 3'd0; wd = 8'h33; a1 = 3'd0;
      @(negedge clk);
      chk("lit_z0_same", rd1_z, 8'h00);
      step();
      we = 1'b0;
      @(negedge clk);
      chk("lit_z0_after", rd1_z, 8'h00);
      chk("lit_r0_plain", rd1, 8'h33);
      step();

      // Full clear.
      fill(8'h10);
      clr_req = 1'b1; we = 1'b1; a3 = 3'd4; wd = 8'hEE;
      step();
      clr_req = 1'b0; we = 1'b0;
      nbusy = 0; ndone = 0;
      count_clear(12);
      chk("busy_cycles", 8'(nbusy), 8'd8);
      chk("done_pulses", 8'(ndone), 8'd1);
      for (int i = 0; i < 8; i++) begin
         a1 = 3'(i);
         @(negedge clk);
         chk("cleared", rd1, 8'h00);
         step();
      end

      // Write and re-request while clearing.
      fill(8'h70);
      clr_req = 1'b1; step(); clr_req = 1'b0;
      nbusy = 0; ndone = 0;
      count_clear(2);
      we = 1'b1; a3 = 3'd5; wd = 8'hFF; clr_req = 1'b1;
      count_clear(10);
      chk("busy_cycles2", 8'(nbusy), 8'd8);
      chk("done_pulses2", 8'(ndone), 8'd1);
      a1 = 3'd5;
      @(negedge clk);
      chk("lit_r5", rd1, 8'h00);
      step();

      // Reset in the middle of a clear.
      fill(8'h20);
      clr_req = 1'b1; step(); clr_req = 1'b0;
      step(); step();
      clr_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", {7'd0, busy}, 8'h00);
      step();
      clr_n = 1'b1;
      nbusy = 0; ndone = 0;
      count_clear(10);
      chk("abort_done", 8'(ndone), 8'd0);
      we = 1'b1; a3 = 3'd1; wd = 8'h44; step();
      we = 1'b0; a1 = 3'd1;
      @(negedge clk);
      chk("lit_r1", rd1, 8'h44);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/banco_registradores_n.md
BANCO_REGISTRADORES_N -- requirements
Module: banco_registradores_n

Interface
REQ-001 Parameter Size, default 8, data word width in bits (>=1).
REQ-002 Parameter AW, default 3, address width; register count N = 2**AW (AW 1..6).
REQ-003 Parameter ZERO_R0, default 0, when 1 register 0 is hardwired to zero.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 clr_n  input  1  asynchronous active-low reset.
REQ-006 we  input  1  write enable.
REQ-007 a3  input  AW  write address.
REQ-008 wd  input  Size  write data.
REQ-009 a1, a2  input  AW each  read addresses for ports 1 and 2.
REQ-010 clr_req  input  1  single-cycle request for sequential bulk clear.
REQ-011 rd1, rd2  output  Size each  read data for ports 1 and 2.
REQ-012 busy  output  1  high while bulk clear runs.
REQ-013 done  output  1  one-cycle pulse at bulk-clear completion.

Function
REQ-014 Storage: N words of Size bits; rd1 = word[a1], rd2 = word[a2], combinational, no latency.
REQ-015 Write accepted when we=1, busy=0, clr_req=0: word[a3] <= wd at the rising edge; visible on reads the following cycle.
REQ-016 Both read ports SHALL address the same word independently, including a1 = a2.
REQ-017 ZERO_R0=1: writes to address 0 discarded; reads of address 0 return 0 regardless of BYPASS_EN.
REQ-018 FSM states IDLE, LIMPA; IDLE and clr_req=1 -> LIMPA, clear counter loaded with 0.
REQ-019 In LIMPA, each cycle word[counter] <= 0 and counter increments by 1; busy = 1.
REQ-020 Counter at N-1 in LIMPA: last word cleared, next state IDLE, done = 1 for that following cycle only; total busy time exactly N cycles.
REQ-021 clr_req and a write in the same IDLE cycle: clr_req wins, write dropped.
REQ-022 clr_req while busy: ignored, no restart, no extension.
REQ-023 we while busy: write dropped, no storage change.
REQ-024 Reads during LIMPA return current contents (already-cleared words 0, others old values).
REQ-025 Counter width AW; no wrap beyond N-1 (transition to IDLE takes precedence).

Reset
REQ-026 clr_n low asynchronously forces all words to 0, state IDLE, counter 0, busy 0, done 0.
REQ-027 Reset asserted during LIMPA aborts the clear; after release block is IDLE, all words 0, no done pulse.
REQ-028 First write accepted on the first rising edge after clr_n deassertion.

Configuration
REQ-029 Macro BANCO_BYPASS_EN defined: when a write is accepted in the current cycle and a1 (or a2) equals a3, rd1 (or rd2) returns wd combinationally (write-through forwarding).
REQ-030 BANCO_BYPASS_EN undefined: reads always return stored contents; the written value appears one cycle after the write edge.
REQ-031 Forwarding SHALL never occur for dropped writes (busy, clr_req, or ZERO_R0 address 0).

Structure
REQ-032 Shared package holds state encoding (IDLE, LIMPA) and default Size/AW constants.
REQ-033 One sub-module, seq_limpeza: FSM plus counter, outputs busy, done, clear address, clear strobe; storage and read muxes stay in the top.

Verification
REQ-034 Reset, write 0x5A to r3, 0xA5 to r7, read a1=3 a2=7 -> rd1=0x5A, rd2=0xA5 next cycle.
REQ-035 Write 0x11 to r2 with a1=2 same cycle -> rd1=0x11 in that cycle with BANCO_BYPASS_EN, old value 0x00 without.
REQ-036 Fill all 8 words, pulse clr_req -> busy high exactly 8 cycles, word k reads 0 from cycle k+1, done one pulse, all reads 0.
REQ-037 During LIMPA write 0xFF to r5 and pulse clr_req again -> write dropped, busy still 8 cycles total, r5 = 0.
REQ-038 ZERO_R0=1, write 0x33 to r0 with a1=0 -> rd1=0 in both configurations.
REQ-039 Assert clr_n at cycle 3 of LIMPA -> all words 0, busy 0, no done pulse; write 0x44 to r1 after release -> rd1=0x44.
